// File: rtl/memory_cycle_if.sv
// MEM-stage bus: M-side instruction fields in, MEM/WB register contents out.
interface memory_cycle_if;
  logic        StallM;
  logic        FlushW;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;
  logic        MisalignW;

  modport master (
    output StallM, FlushW, RegWriteM, MemWriteM, ResultSrcM, funct3M,
           RD_M, PCPlus4M, ALU_ResultM, WriteDataM,
    input  RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
           ReadDataW, MisalignW
  );

  modport slave (
    input  StallM, FlushW, RegWriteM, MemWriteM, ResultSrcM, funct3M,
           RD_M, PCPlus4M, ALU_ResultM, WriteDataM,
    output RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW,
           ReadDataW, MisalignW
  );
endinterface

// File: rtl/memory_cycle.sv
// RV32I memory stage: byte/half/word loads and stores on an internal data
// memory, followed by the MEM/WB pipeline register.
module memory_cycle #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst,
  memory_cycle_if.slave  bus
);

  // Sign/zero-extend the addressed lane of a memory word; funct3[1:0]
  // selects size, so the undefined codes fall through to a word access.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge store data into the old word, leaving untouched lanes intact.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          2'd3:    r[31:24] = data[7:0];
          default: r = old;
        endcase
      end
      2'b01:   r = lane[1] ? {data[15:0], old[15:0]} : {old[31:16], data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

  // Natural alignment check for the access size encoded in funct3.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = lane[0];
      default: r = (lane != 2'd0);
    endcase
    return r;
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] word_idx_s;
  logic [1:0]        lane_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       wr_word_s;
  logic [31:0]       load_data_s;
  logic              mem_access_s;
  logic              misalign_s;
  logic              store_en_s;
  logic              regwrite_s;

  logic              regwrite_w_r;
  logic              resultsrc_w_r;
  logic [4:0]        rd_w_r;
  logic [31:0]       pcplus4_w_r;
  logic [31:0]       alu_result_w_r;
  logic [31:0]       read_data_w_r;
  logic              misalign_w_r;

  assign word_idx_s = bus.ALU_ResultM[ADDR_W+1:2];
  assign lane_s     = bus.ALU_ResultM[1:0];
  assign rd_word_s  = mem_r[word_idx_s];

  // Decode the access: alignment, store enable, extracted load data.
  always_comb begin
    mem_access_s = bus.ResultSrcM | bus.MemWriteM;
    misalign_s   = mem_access_s & is_misaligned(bus.funct3M, lane_s);
    wr_word_s    = store_merge(rd_word_s, bus.WriteDataM, lane_s, bus.funct3M);
    store_en_s   = bus.MemWriteM & ~bus.StallM & ~bus.FlushW & ~rst & ~misalign_s;
    regwrite_s   = bus.RegWriteM & ~misalign_s;
    if (misalign_s) begin
      load_data_s = 32'd0;
    end else begin
      load_data_s = load_extract(rd_word_s, lane_s, bus.funct3M);
    end
  end

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (store_en_s) begin
      mem_r[word_idx_s] <= wr_word_s;
    end
  end

  // MEM/WB register: reset beats flush beats stall beats normal load.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushW) begin
      regwrite_w_r   <= 1'b0;
      resultsrc_w_r  <= 1'b0;
      rd_w_r         <= 5'd0;
      pcplus4_w_r    <= 32'd0;
      alu_result_w_r <= 32'd0;
      read_data_w_r  <= 32'd0;
      misalign_w_r   <= 1'b0;
    end else if (!bus.StallM) begin
      regwrite_w_r   <= regwrite_s;
      resultsrc_w_r  <= bus.ResultSrcM;
      rd_w_r         <= bus.RD_M;
      pcplus4_w_r    <= bus.PCPlus4M;
      alu_result_w_r <= bus.ALU_ResultM;
      read_data_w_r  <= load_data_s;
      misalign_w_r   <= misalign_s;
    end else begin
      regwrite_w_r   <= regwrite_w_r;
      resultsrc_w_r  <= resultsrc_w_r;
      rd_w_r         <= rd_w_r;
      pcplus4_w_r    <= pcplus4_w_r;
      alu_result_w_r <= alu_result_w_r;
      read_data_w_r  <= read_data_w_r;
      misalign_w_r   <= misalign_w_r;
    end
  end

  assign bus.RegWriteW   = regwrite_w_r;
  assign bus.ResultSrcW  = resultsrc_w_r;
  assign bus.RD_W        = rd_w_r;
  assign bus.PCPlus4W    = pcplus4_w_r;
  assign bus.ALU_ResultW = alu_result_w_r;
  assign bus.ReadDataW   = read_data_w_r;
  assign bus.MisalignW   = misalign_w_r;

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory (M) stage of the 5-stage RV32I pipeline: performs byte/halfword/word loads and stores against an internal data memory and registers the results into the MEM/WB pipeline register. Sits between the execute stage and the writeback stage. Its W-side outputs drive the writeback stage's result mux and the register-file write port directly.

## Interface
- DEPTH, 1024: data memory size in 32-bit words; power of two
- ADDR_W, 10: word-address width, equal to log2(DEPTH)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallM  in  1  hold: MEM/WB register keeps its value; store suppressed
- FlushW  in  1  kill the instruction in M: store suppressed, bubble into W
- RegWriteM  in  1  instruction writes rd
- MemWriteM  in  1  instruction is a store
- ResultSrcM  in  1  0 = ALU result, 1 = load data
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- RD_M  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- ALU_ResultM  in  32  effective byte address, or ALU result
- WriteDataM  in  32  store data (rs2)
- RegWriteW  out  1  registered RegWriteM, gated by misalign
- ResultSrcW  out  1  registered ResultSrcM
- RD_W  out  5  registered RD_M
- PCPlus4W  out  32  registered PCPlus4M
- ALU_ResultW  out  32  registered ALU_ResultM
- ReadDataW  out  32  registered, extended load data
- MisalignW  out  1  registered misaligned-access flag

## Operation
- Memory: DEPTH x 32 array. Word index = ALU_ResultM[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes. Memory contents are not cleared by rst.
- Read: combinational from the word index in the M cycle.
- Load extract: B/BU take byte lane ALU_ResultM[1:0]; H/HU take the halfword at ALU_ResultM[1]; W takes the whole word. B/H sign-extend; BU/HU zero-extend.
- Store: SB writes WriteDataM[7:0] to lane [1:0]. SH writes WriteDataM[15:0] to halfword [1]. SW writes the full word. Other lanes are unchanged.
- Undefined funct3 (011, 110, 111): treated as word access.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Misaligned store: suppressed.
  - Misaligned load: ReadDataW=0.
  - For any instruction with ResultSrcM=1 or MemWriteM=1, misalign forces RegWriteW=0 and MisalignW=1.
  - Misalign checking applies only when ResultSrcM=1 or MemWriteM=1.
- Store commit condition: MemWriteM & ~StallM & ~FlushW & ~rst & aligned.
- MEM/WB register priority, evaluated each edge:
  1. rst: all W outputs become 0.
  2. FlushW: bubble, all W outputs become 0.
  3. StallM: hold all W outputs.
  4. Otherwise: load from the M-side values.

## Timing
- Reset: RegWriteW, ResultSrcW, MisalignW = 0; RD_W = 0; PCPlus4W, ALU_ResultW, ReadDataW = 0.
- Latency:
  - Store writes memory on the edge ending its M cycle.
  - Load data appears on ReadDataW one cycle after the address is presented on ALU_ResultM.
- Store at cycle n followed by a load to the same word at n+1: the load returns the new data. There is no same-cycle read/write conflict, since only one instruction occupies M.
- StallM held for k cycles: W outputs are frozen for k cycles, and a pending store commits exactly once, on the first non-stalled, non-flushed edge.
- FlushW together with StallM: flush wins, and the store does not commit.
- rst asserted while a store is in M: the store is discarded.

## Test plan
- Reset: assert rst for 2 cycles with random M inputs -> all W outputs read 0 and the memory word is unchanged.
- Word round trip: SW 0xDEADBEEF to 0x40, then LW 0x40 -> ReadDataW=0xDEADBEEF, RegWriteW=1, ResultSrcW=1.
- Sub-word stores and loads: after SW 0x11223344 to 0x80, SB 0xAA to 0x81 -> word reads 0x1122AA44.
  - LB 0x81 -> 0xFFFFFFAA; LBU 0x81 -> 0x000000AA.
  - LH 0x82 -> 0x00001122; SH 0x8000 to 0x82 then LH 0x82 -> 0xFFFF8000.
- Misalign: LW at 0x42 -> MisalignW=1, RegWriteW=0, ReadDataW=0. SH at 0x43 -> memory word 0x40 unchanged.
- Stall and flush:
  - SW 0x5 to 0x10 with StallM high for 3 cycles -> W outputs frozen and the store commits once after release.
  - Same store with FlushW=1 -> word 0x10 unchanged and W outputs become a bubble.
- Wrap: with DEPTH=1024, SW 0x77 to 0x1000 then LW 0x0 -> 0x77.
